updown_sweep_ctrl: RTL and testbench
====================================

# updown_sweep_ctrl

Sequencing controller for the 4-bit up/down counter. It drives the counter's clear and direction (flag) inputs so the counter performs a programmed number of triangular sweeps between a low and a high limit, then parks it at zero. It sits beside the counter, which counts on every clk edge. It gives a start/done handshake to the test or control logic above it.

## Interface
- WIDTH, 4, counter width; must match the counter.
- SWEEPS_W, 4, width of sweep count fields.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  terminate a run; sampled in UP/DOWN.
- lo_limit  in  WIDTH  sweep lower turning point; latched at start.
- hi_limit  in  WIDTH  sweep upper turning point; latched at start.
- num_sweeps  in  SWEEPS_W  round trips to perform; latched at start.
- count_in  in  WIDTH  current counter value.
- ctr_reset  out  1  active-high clear to counter; combinational from state.
- ctr_flag  out  1  counter direction, 0 = up, 1 = down; combinational from state and count_in.
- busy  out  1  high in UP/DOWN.
- done  out  1  one-cycle pulse on normal completion.
- sweep_cnt  out  SWEEPS_W  completed round trips in current/last run.
- err  out  1  invalid-start pulse (only with SWEEP_CHECK_EN).

## Operation
- States: IDLE, UP, DOWN, DONE.
- IDLE: ctr_reset=1, ctr_flag=0, so the counter is held at 0.
  - start=1 and abort=0: latch the limits and num_sweeps; clear sweep_cnt.
  - If num_sweeps==0, go to DONE. Otherwise go to UP.
- UP: ctr_reset=0.
  - If count_in==hi_lat: ctr_flag=1 in the same cycle and go to DOWN. The counter therefore turns without overshoot.
  - Otherwise ctr_flag=0.
- DOWN: ctr_reset=0.
  - If count_in==lo_lat: increment sweep_cnt.
    - If the new sweep_cnt==num_lat, go to DONE with ctr_flag=0.
    - Otherwise ctr_flag=0 and go to UP.
  - Otherwise ctr_flag=1.
- DONE: ctr_reset=1, done=1 for exactly one cycle, then go to IDLE.
- abort=1 in UP/DOWN: go to IDLE at the next edge.
  - done is not pulsed; sweep_cnt holds its value.
  - abort has priority over the limit comparisons.
- start outside IDLE is ignored. start and abort together in IDLE: stay in IDLE.
- First sweep rises from 0 to hi_lat. Later sweeps rise from lo_lat.
- lo_lat==0 is legal: the turn happens at count_in==0, so the counter never wraps.
- sweep_cnt saturates at its maximum. It is compared using SWEEPS_W-bit equality.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, ctr_reset=1, ctr_flag=0, busy=0, done=0, sweep_cnt=0, err=0. Latched limits clear to 0.
- Start latency: start sampled at edge N, so ctr_reset=0 during cycle N+1 and the counter leaves 0 at edge N+1.
- Turn latency: zero. ctr_flag changes in the same cycle count_in hits a limit.
- done asserts in the cycle after the edge where the final count_in==lo_lat was seen. ctr_reset=1 in that same cycle.
- Reset asserted mid-run: immediate return to IDLE, no done.

## Configuration
- SWEEP_CHECK_EN defined: start in IDLE is rejected if lo_limit>=hi_limit.
  - Rejection gives err=1 for one cycle, state stays IDLE, and nothing is latched.
- SWEEP_CHECK_EN undefined: the err port is removed and every start is accepted. Behaviour with lo_limit>=hi_limit is unspecified.

## Structure
- Package sweep_pkg holds:
  - the state enum typedef (IDLE, UP, DOWN, DONE);
  - direction constants DIR_UP=1'b0 and DIR_DOWN=1'b1.
- Single module. The logic is one FSM plus a sweep counter, so no sub-module is warranted.
- Bench pairs the block with the existing up/down counter: ctr_reset drives the counter reset, ctr_flag drives flag, and the counter output feeds count_in.

## Test plan
- lo=2, hi=5, n=2, start pulse:
  - count_in sequence is 0,1,2,3,4,5,4,3,2,3,4,5,4,3,2;
  - done pulses once in the next cycle;
  - sweep_cnt=2;
  - the counter then reads 0.
- lo=0, hi=15, n=1: counter runs 0..15..0 with no wrap past 15 or 0; done once; sweep_cnt=1.
- n=0, start: done pulses in the cycle after start, busy never rises, counter stays 0.
- lo=1, hi=6, n=3, abort raised when count_in==4 on the second rise:
  - IDLE at the next edge, no done, sweep_cnt=1, counter cleared.
- reset pulled low mid-DOWN (count_in=3):
  - all outputs immediately take their reset values;
  - after release, start is accepted normally.
- With SWEEP_CHECK_EN, lo=5, hi=5, start: err one cycle, stay IDLE, busy=0. A later valid start runs normally.

Source files
------------

// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared types for the up/down sweep controller: FSM state encoding and counter direction codes.
package sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown,
    StDone
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// Host and counter-side signal bundle for updown_sweep_ctrl.
// The err signal exists only when SWEEP_CHECK_EN is defined.
interface updown_sweep_ctrl_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SWEEPS_W = 4
);
  logic                start;
  logic                abort;
  logic [WIDTH-1:0]    lo_limit;
  logic [WIDTH-1:0]    hi_limit;
  logic [SWEEPS_W-1:0] num_sweeps;
  logic [WIDTH-1:0]    count_in;
  logic                ctr_reset;
  logic                ctr_flag;
  logic                busy;
  logic                done;
  logic [SWEEPS_W-1:0] sweep_cnt;
`ifdef SWEEP_CHECK_EN
  logic                err;

  modport master (
    output start, abort, lo_limit, hi_limit, num_sweeps, count_in,
    input  ctr_reset, ctr_flag, busy, done, sweep_cnt, err
  );
  modport slave (
    input  start, abort, lo_limit, hi_limit, num_sweeps, count_in,
    output ctr_reset, ctr_flag, busy, done, sweep_cnt, err
  );
`else
  modport master (
    output start, abort, lo_limit, hi_limit, num_sweeps, count_in,
    input  ctr_reset, ctr_flag, busy, done, sweep_cnt
  );
  modport slave (
    input  start, abort, lo_limit, hi_limit, num_sweeps, count_in,
    output ctr_reset, ctr_flag, busy, done, sweep_cnt
  );
`endif
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Drives an up/down counter through a programmed number of triangular sweeps, then parks it at 0.
// SWEEP_CHECK_EN adds rejection of starts with lo_limit >= hi_limit, reported on err.
module updown_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SWEEPS_W = 4
) (
  input logic                clk,
  input logic                reset,
  updown_sweep_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [SWEEPS_W-1:0] num_q, num_d;
  logic [SWEEPS_W-1:0] cnt_q, cnt_d;
  logic [SWEEPS_W-1:0] cnt_inc;
  logic                start_valid;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + SWEEPS_W'(1);

`ifdef SWEEP_CHECK_EN
  logic err_q, err_d;
  assign start_valid = (bus.lo_limit < bus.hi_limit);
  assign bus.err     = err_q;
`else
  assign start_valid = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    num_d         = num_q;
    cnt_d         = cnt_q;
    bus.ctr_reset = 1'b1;
    bus.ctr_flag  = DIR_UP;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
`ifdef SWEEP_CHECK_EN
    err_d         = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          if (start_valid) begin
            lo_d    = bus.lo_limit;
            hi_d    = bus.hi_limit;
            num_d   = bus.num_sweeps;
            cnt_d   = '0;
            state_d = (bus.num_sweeps == '0) ? StDone : StUp;
          end else begin
`ifdef SWEEP_CHECK_EN
            err_d = 1'b1;
`endif
          end
        end
      end
      StUp: begin
        bus.ctr_reset = 1'b0;
        bus.busy      = 1'b1;
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.count_in == hi_q) begin
          // Turn in the same cycle the limit is seen so the counter never overshoots.
          bus.ctr_flag = DIR_DOWN;
          state_d      = StDown;
        end
      end
      StDown: begin
        bus.ctr_reset = 1'b0;
        bus.busy      = 1'b1;
        bus.ctr_flag  = DIR_DOWN;
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.count_in == lo_q) begin
          bus.ctr_flag = DIR_UP;
          cnt_d        = cnt_inc;
          state_d      = (cnt_inc == num_q) ? StDone : StUp;
        end
      end
      StDone: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      lo_q    <= '0;
      hi_q    <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SWEEP_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  assign bus.sweep_cnt = cnt_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl paired with a behavioural 4-bit up/down counter.
// Expected count trajectories are built from the sweep rules as plain integer sequences.
module tb_updown_sweep_ctrl;
  localparam int unsigned WIDTH    = 4;
  localparam int unsigned SWEEPS_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic [WIDTH-1:0] ctr_q;
  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  updown_sweep_ctrl_if #(.WIDTH(WIDTH), .SWEEPS_W(SWEEPS_W)) bus ();

  updown_sweep_ctrl #(.WIDTH(WIDTH), .SWEEPS_W(SWEEPS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // The counter being sequenced: synchronous clear, flag selects direction.
  always @(posedge clk) begin
    if (bus.ctr_reset)     ctr_q <= '0;
    else if (bus.ctr_flag) ctr_q <= ctr_q - 1'b1;
    else                   ctr_q <= ctr_q + 1'b1;
  end
  assign bus.count_in = ctr_q;

  // Count values seen while busy: rise 0..hi, then n descents to lo with re-rises lo+1..hi between.
  function automatic void build_seq(input int lo, input int hi, input int n);
    exp_q.delete();
    if (n == 0) return;
    for (int v = 0; v <= hi; v++) exp_q.push_back(v);
    for (int s = 1; s <= n; s++) begin
      for (int v = hi - 1; v >= lo; v--) exp_q.push_back(v);
      if (s < n) for (int v = lo + 1; v <= hi; v++) exp_q.push_back(v);
    end
  endfunction

  function automatic logic exp_flag(input int idx);
    if (idx + 1 < exp_q.size()) return (exp_q[idx + 1] < exp_q[idx]);
    return 1'b0;
  endfunction

  task automatic launch(input int lo, input int hi, input int n);
    bus.lo_limit   = WIDTH'(lo);
    bus.hi_limit   = WIDTH'(hi);
    bus.num_sweeps = SWEEPS_W'(n);
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.lo_limit = '0; bus.hi_limit = '0; bus.num_sweeps = '0;
    #1;
    checks++;
    if (bus.ctr_reset !== 1'b1 || bus.ctr_flag !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.sweep_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rst=%b flag=%b busy=%b done=%b cnt=%0d want 1 0 0 0 0",
               bus.ctr_reset, bus.ctr_flag, bus.busy, bus.done, bus.sweep_cnt);
    end
`ifdef SWEEP_CHECK_EN
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
`endif
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || ctr_q !== '0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b ctr=%0d want 0 0", bus.busy, ctr_q);
    end
  endtask

  task automatic test_sweep(input string name, input int lo, input int hi, input int n);
    int idx = 0;
    int guard = 0;
    build_seq(lo, hi, n);
    launch(lo, hi, n);
    while (bus.busy === 1'b1 && guard < 400) begin
      checks++;
      if (idx >= exp_q.size()) begin
        errors++;
        $display("FAIL %s_overrun: got busy at step %0d want idle after %0d", name, idx,
                 exp_q.size());
      end else if (ctr_q !== WIDTH'(exp_q[idx]) || bus.ctr_flag !== exp_flag(idx) ||
                   bus.done !== 1'b0 || bus.ctr_reset !== 1'b0) begin
        errors++;
        $display("FAIL %s_step%0d: got ctr=%0d flag=%b done=%b rst=%b want ctr=%0d flag=%b 0 0",
                 name, idx, ctr_q, bus.ctr_flag, bus.done, bus.ctr_reset, exp_q[idx],
                 exp_flag(idx));
      end
      idx++; guard++;
      @(negedge clk);
    end
    checks++;
    if (idx != exp_q.size()) begin
      errors++;
      $display("FAIL %s_length: got %0d busy cycles want %0d", name, idx, exp_q.size());
    end
    checks++;
    if (bus.done !== 1'b1 || bus.ctr_reset !== 1'b1 || bus.sweep_cnt !== SWEEPS_W'(n)) begin
      errors++;
      $display("FAIL %s_done: got done=%b rst=%b cnt=%0d want 1 1 %0d", name, bus.done,
               bus.ctr_reset, bus.sweep_cnt, n);
    end
    if (n == 0) begin
      checks++;
      if (ctr_q !== '0) begin errors++; $display("FAIL %s_held: got ctr=%0d want 0", name, ctr_q); end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || ctr_q !== '0 || bus.sweep_cnt !== SWEEPS_W'(n)) begin
      errors++;
      $display("FAIL %s_park: got done=%b busy=%b ctr=%0d cnt=%0d want 0 0 0 %0d", name,
               bus.done, bus.busy, ctr_q, bus.sweep_cnt, n);
    end
  endtask

  task automatic test_abort();
    int idx = 0;
    int guard = 0;
    int abort_idx = -1;
    build_seq(1, 6, 3);
    for (int i = 7; i < exp_q.size(); i++)
      if (abort_idx < 0 && exp_q[i] == 4 && exp_q[i - 1] == 3) abort_idx = i;
    launch(1, 6, 3);
    while (bus.busy === 1'b1 && guard < 400 && idx != abort_idx) begin
      idx++; guard++;
      @(negedge clk);
    end
    checks++;
    if (idx != abort_idx || ctr_q !== 4'd4) begin
      errors++;
      $display("FAIL abort_reach: got step %0d ctr=%0d want step %0d ctr=4", idx, ctr_q,
               abort_idx);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sweep_cnt !== 4'd1 ||
        bus.ctr_reset !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b done=%b cnt=%0d rst=%b want 0 0 1 1", bus.busy,
               bus.done, bus.sweep_cnt, bus.ctr_reset);
    end
    @(negedge clk);
    checks++;
    if (ctr_q !== '0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: got ctr=%0d done=%b want 0 0", ctr_q, bus.done);
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    int guard = 0;
    int hit = -1;
    int seen = 0;
    build_seq(1, 6, 3);
    // Second descent through 3, so sweep_cnt is already nonzero when reset hits.
    for (int i = 1; i < exp_q.size(); i++)
      if (exp_q[i] == 3 && exp_q[i - 1] == 4) begin
        seen++;
        if (seen == 2 && hit < 0) hit = i;
      end
    launch(1, 6, 3);
    while (bus.busy === 1'b1 && guard < 400 && idx != hit) begin
      idx++; guard++;
      @(negedge clk);
    end
    checks++;
    if (idx != hit || ctr_q !== 4'd3 || bus.sweep_cnt !== 4'd1) begin
      errors++;
      $display("FAIL rstmid_reach: got step %0d ctr=%0d cnt=%0d want step %0d ctr=3 cnt=1",
               idx, ctr_q, bus.sweep_cnt, hit);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.ctr_reset !== 1'b1 || bus.ctr_flag !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.sweep_cnt !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got rst=%b flag=%b busy=%b done=%b cnt=%0d want 1 0 0 0 0",
               bus.ctr_reset, bus.ctr_flag, bus.busy, bus.done, bus.sweep_cnt);
    end
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_abort();
    bus.lo_limit = 4'd2; bus.hi_limit = 4'd5; bus.num_sweeps = 4'd1;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ctr_reset !== 1'b1) begin
      errors++;
      $display("FAIL start_abort: got busy=%b done=%b rst=%b want 0 0 1", bus.busy, bus.done,
               bus.ctr_reset);
    end
  endtask

`ifdef SWEEP_CHECK_EN
  task automatic test_err();
    launch(5, 5, 2);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got err=%b busy=%b done=%b want 1 0 0", bus.err, bus.busy,
               bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err=%b busy=%b want 0 0", bus.err, bus.busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep("basic", 2, 5, 2);
    test_sweep("full_range", 0, 15, 1);
    test_sweep("zero_sweeps", 3, 9, 0);
    test_abort();
    test_reset_mid();
    test_sweep("after_reset", 1, 6, 2);
    test_start_abort();
`ifdef SWEEP_CHECK_EN
    test_err();
    test_sweep("after_err", 4, 7, 1);
`endif
    for (int r = 0; r < 6; r++) begin
      int lo = int'($urandom_range(0, 13));
      int hi = int'($urandom_range(lo + 1, 15));
      int n  = int'($urandom_range(1, 3));
      test_sweep($sformatf("rand%0d", r), lo, hi, n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
